// File: rtl/servo_bank.sv
// Multi-channel hobby-servo PWM generator sharing one tick prescaler and frame counter.
// Define SERVO_SLEW_EN to rate-limit committed positions by SLEW_STEP per frame.
module servo_bank #(
  parameter int NCH       = 4,
  parameter int DIV       = 47,
  parameter int POS_W     = 8,
  parameter int FRAME_W   = 12,
  parameter int OFFSET    = 256,
  parameter int SLEW_STEP = 4,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [POS_W-1:0] wr_pos,
  input  logic             wr_en,
  output logic [NCH-1:0]   servo,
  output logic             frame_start
);

  localparam int PS_W = $clog2(DIV);
  localparam logic [POS_W-1:0] POS_MID = POS_W'(2 ** (POS_W - 1));

  if (DIV < 2 || NCH < 1 || NCH > 16 || SLEW_STEP < 0 ||
      OFFSET + 2 ** POS_W - 1 >= 2 ** FRAME_W) begin : g_bad_params
    $error("servo_bank: illegal parameter combination");
  end

  logic [PS_W-1:0]    prescaler;
  logic [FRAME_W-1:0] frame_cnt;
  logic               tic;
  logic               commit;

  logic [POS_W-1:0]   shadow_pos [NCH];
  logic [POS_W-1:0]   active_pos [NCH];
  logic [NCH-1:0]     shadow_en;
  logic [NCH-1:0]     active_en;
  logic               wr_hit;

  // Pulse ends once the frame counter reaches OFFSET + pos; legality keeps the sum in range.
  function automatic logic [FRAME_W-1:0] pulse_end(input logic [POS_W-1:0] pos);
    return FRAME_W'(OFFSET) + FRAME_W'(pos);
  endfunction

`ifdef SERVO_SLEW_EN
  localparam logic signed [POS_W+1:0] STEP_S = (POS_W + 2)'(SLEW_STEP);

  function automatic logic [POS_W-1:0] slew(input logic [POS_W-1:0] cur,
                                            input logic [POS_W-1:0] tgt);
    logic signed [POS_W+1:0] delta;
    delta = $signed({2'b00, tgt}) - $signed({2'b00, cur});
    if (delta > STEP_S)
      return cur + POS_W'(SLEW_STEP);
    else if (delta < -STEP_S)
      return cur - POS_W'(SLEW_STEP);
    else
      return tgt;
  endfunction
`endif

  assign tic    = (prescaler == PS_W'(DIV - 1));
  assign commit = tic && (&frame_cnt);
  assign wr_hit = wr && (int'(wr_ch) < NCH);

  // Timebase: tick prescaler and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler   <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      prescaler   <= tic ? '0 : prescaler + PS_W'(1);
      if (tic)
        frame_cnt <= frame_cnt + FRAME_W'(1);
      frame_start <= commit;
    end
  end

  // Shadow registers take writes at any time; active copies change only on commit
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_en <= '0;
      active_en <= '0;
      for (int i = 0; i < NCH; i++) begin
        shadow_pos[i] <= POS_MID;
        active_pos[i] <= POS_MID;
      end
    end else begin
      if (commit) begin
        active_en <= shadow_en;
        for (int i = 0; i < NCH; i++) begin
`ifdef SERVO_SLEW_EN
          active_pos[i] <= slew(active_pos[i], shadow_pos[i]);
`else
          active_pos[i] <= shadow_pos[i];
`endif
        end
      end
      if (wr_hit) begin
        shadow_pos[wr_ch] <= wr_pos;
        shadow_en[wr_ch]  <= wr_en;
      end
    end
  end

  // Output stage: registered compare against the live frame position
  always_ff @(posedge clk) begin
    if (rst) begin
      servo <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        servo[i] <= active_en[i] && (frame_cnt < pulse_end(active_pos[i]));
    end
  end

endmodule

// File: tb/tb_servo_bank.sv
// Scoreboard bench for servo_bank: expected per-frame pulse widths are queued as writes
// are issued and compared against widths measured between frame_start pulses.
module tb_servo_bank;

  localparam int NCH       = 3;
  localparam int DIV       = 3;
  localparam int POS_W     = 8;
  localparam int FRAME_W   = 9;
  localparam int OFFSET    = 200;
  localparam int SLEW_STEP = 4;
  localparam int CH_W      = 2;
  localparam int P         = DIV * (2 ** FRAME_W);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr = 1'b0;
  logic [CH_W-1:0]  wr_ch = '0;
  logic [POS_W-1:0] wr_pos = '0;
  logic             wr_en = 1'b0;
  logic [NCH-1:0]   servo;
  logic             frame_start;

  servo_bank #(
    .NCH(NCH), .DIV(DIV), .POS_W(POS_W), .FRAME_W(FRAME_W),
    .OFFSET(OFFSET), .SLEW_STEP(SLEW_STEP)
  ) dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_ch(wr_ch), .wr_pos(wr_pos),
    .wr_en(wr_en), .servo(servo), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];
  int sh_pos [NCH];
  int act_pos[NCH];
  bit sh_en  [NCH];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic finish_tb();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  function automatic int slew_m(input int cur, input int tgt);
`ifdef SERVO_SLEW_EN
    if (tgt - cur > SLEW_STEP) return cur + SLEW_STEP;
    if (cur - tgt > SLEW_STEP) return cur - SLEW_STEP;
`endif
    return tgt;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      sh_pos[i]  = 2 ** (POS_W - 1);
      act_pos[i] = 2 ** (POS_W - 1);
      sh_en[i]   = 1'b0;
    end
  endtask

  // Expected widths for the frame following the next commit
  task automatic push_next();
    for (int i = 0; i < NCH; i++) begin
      act_pos[i] = slew_m(act_pos[i], sh_pos[i]);
      exp_q.push_back(sh_en[i] ? (OFFSET + act_pos[i]) * DIV : 0);
    end
  endtask

  task automatic do_wr(input int ch, input int pos, input bit en);
    wr     = 1'b1;
    wr_ch  = CH_W'(ch);
    wr_pos = POS_W'(pos);
    wr_en  = en;
    @(negedge clk);
    wr = 1'b0;
    if (ch < NCH) begin
      sh_pos[ch] = pos;
      sh_en[ch]  = en;
    end
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 2 * P);
    if (!frame_start) begin
      chk("fs_timeout", 0, 1);
      finish_tb();
    end
  endtask

  // Monitor: measures each complete frame and checks it against the scoreboard
  int cyc;
  int hi  [NCH];
  int rise[NCH];
  bit armed = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      armed = 1'b0;
    end else if (frame_start) begin
      if (armed) begin
        chk("period", cyc + 1, P);
        if (exp_q.size() < NCH) begin
          chk("sb_empty", exp_q.size(), NCH);
        end else begin
          for (int i = 0; i < NCH; i++) begin
            int e;
            e = exp_q.pop_front();
            chk($sformatf("width_ch%0d", i), hi[i], e);
            if (e > 0) chk($sformatf("rise_ch%0d", i), rise[i], 1);
          end
        end
      end
      armed = 1'b1;
      cyc   = 0;
      for (int i = 0; i < NCH; i++) begin
        hi[i]   = 0;
        rise[i] = -1;
      end
    end else if (armed) begin
      cyc++;
      for (int i = 0; i < NCH; i++) begin
        if (servo[i]) begin
          hi[i]++;
          if (rise[i] < 0) rise[i] = cyc;
        end
      end
    end
  end

  initial begin
    int k;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_servo", int'(servo), 0);
    chk("rst_fs", int'(frame_start), 0);
    rst = 1'b0;
    push_next();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 2 * P);
    chk("first_fs", k, P);
    if (!frame_start) finish_tb();

    push_next(); wait_fs();
    push_next(); wait_fs();

    do_wr(0, 0, 1'b1);
    push_next(); wait_fs();

    do_wr(1, 255, 1'b1);
    do_wr(2, 128, 1'b1);
    push_next(); wait_fs();

    // All enabled channels rise together; ch0 is disabled mid-pulse
    @(negedge clk);
    chk("rise_all", int'(servo), 7);
    do_wr(0, 200, 1'b0);
    push_next(); wait_fs();

    do_wr(0, 200, 1'b1);
    push_next(); wait_fs();

    do_wr(3, 0, 1'b0);
    do_wr(2, 10, 1'b1);
    do_wr(2, 50, 1'b1);
    push_next(); wait_fs();

    // Write landing exactly on the commit edge
    push_next();
    repeat (P - 1) @(negedge clk);
    do_wr(0, 0, 1'b1);
    chk("fs_at_commit", int'(frame_start), 1);
    push_next(); wait_fs();
    push_next(); wait_fs();

    // Reset in the middle of a live pulse
    @(negedge clk);
    chk("pre_rst_pulse", int'(servo[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_servo", int'(servo), 0);
    chk("mid_rst_fs", int'(frame_start), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    push_next(); wait_fs();
    push_next(); wait_fs();
    push_next(); wait_fs();

    do_wr(1, 64, 1'b1);
    push_next(); wait_fs();
    push_next(); wait_fs();
    finish_tb();
  end

endmodule

// File: doc/servo_bank.md
Name: servo_bank

Overview:
- Multi-channel hobby-servo PWM generator. Drives NCH servos from one shared tick prescaler and one frame counter.
- Per-channel position and enable are written through a single-cycle write port. Writes are buffered in shadow registers and committed only at frame boundaries, so pulses are never glitched or truncated.
- Sits between the control logic (UART/command decoder) and the servo output pins.

Parameters:
- NCH, 4, number of servo channels (1..16)
- DIV, 47, system clocks per tick (>=2)
- POS_W, 8, position width in bits
- FRAME_W, 12, frame counter width; frame = 2^FRAME_W ticks
- OFFSET, 256, minimum pulse width in ticks (pulse for pos=0)
- SLEW_STEP, 4, max position change per frame; used only with SERVO_SLEW_EN
- Legality: OFFSET + 2^POS_W - 1 < 2^FRAME_W. CH_W = max(1, clog2(NCH)).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr  in  1  write strobe, single cycle
- wr_ch  in  CH_W  target channel
- wr_pos  in  POS_W  target position
- wr_en  in  1  channel enable to be written
- servo  out  NCH  PWM outputs, bit i = channel i, registered
- frame_start  out  1  one-clk pulse at each frame wrap, registered

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high; all state is cleared on the rst edge.
- Reset values:
  - prescaler = 0, frame_cnt = 0
  - shadow_pos = active_pos = 2^(POS_W-1) for every channel
  - shadow_en = active_en = 0
  - servo = 0, frame_start = 0
- Prescaler:
  - Counts 0..DIV-1.
  - tic is a one-cycle internal pulse whenever prescaler == DIV-1, so the tick period is exactly DIV clocks.
  - The first tic occurs DIV cycles after rst deasserts.
- Frame counter:
  - Increments on tic and wraps from 2^FRAME_W-1 to 0.
  - The wrap is the commit event: tic with frame_cnt at max.
  - On the commit cycle: active_en <= shadow_en, active_pos <= shadow_pos (or the slewed value), and frame_start <= 1 on the next clk edge.
- Write port:
  - When wr=1 and wr_ch < NCH: shadow_pos[wr_ch] <= wr_pos and shadow_en[wr_ch] <= wr_en.
  - When wr_ch >= NCH the write is silently ignored.
  - A write never affects the frame currently being output.
  - Write coincident with commit: active takes the pre-write shadow; the new value commits at the following frame.
  - Back-to-back writes to the same channel within one frame: last write wins.
- Output:
  - servo[i] <= active_en[i] && (frame_cnt < OFFSET + active_pos[i]), registered.
  - The comparison is done at FRAME_W bits, with zero-extension.
  - Pulse rises one clk after frame_start rises. Pulse width = (OFFSET + pos) * DIV clocks.
  - All enabled channels rise on the same cycle.
  - A disabled channel stays 0 for the whole frame.
  - Disabling takes effect at the next frame only, so an in-progress pulse completes.
- Reset asserted mid-operation:
  - servo and frame_start are 0 on the cycle after the rst edge.
  - Pending shadow writes are lost.

Optional Feature:
- Macro: SERVO_SLEW_EN.
- Defined: at each commit, active_pos moves toward shadow_pos by at most SLEW_STEP.
  - If |shadow - active| <= SLEW_STEP, active = shadow.
  - Otherwise active = active ± SLEW_STEP.
  - Arithmetic is unsigned with no wrap; the result is always between the old active and the target.
  - Enable still commits immediately at the frame boundary.
- Undefined: active_pos <= shadow_pos directly. SLEW_STEP is unused; no slew logic is synthesised.

Test Plan:
(Defaults, SERVO_SLEW_EN undefined unless noted. Frame = 4096 * 47 = 192512 clks.)
- Reset, no writes for 3 frames:
  - servo stays 4'b0000.
  - frame_start pulses exactly every 192512 clks, first at 192512 clks after rst release.
- Write ch0 pos=0 en=1:
  - From the next frame, servo[0] is high 12032 clks (256 * 47) per frame.
  - servo[3:1] stay 0.
- Write ch1 pos=255 en=1 and ch2 pos=128 en=1:
  - servo[1] high 24017 clks; servo[2] high 18048 clks.
  - Both rise on the same cycle, one clk after frame_start.
- While servo[0] is high (pos=0), write ch0 pos=200 en=0:
  - Current pulse still 12032 clks.
  - Next frame servo[0] stays 0.
  - Re-enable with pos=200 gives 21432 clks the frame after commit.
- Write ch0 on the exact commit cycle:
  - Old value is used for one frame, new value the next.
- With NCH=3, write wr_ch=3:
  - No channel changes.
- Assert rst mid-pulse:
  - servo=0 next cycle; no pulses until re-enabled.
- With SERVO_SLEW_EN and SLEW_STEP=4, ch0 enabled at pos=128, then write pos=140:
  - Successive frames give pos 132, 136, 140, 140.
  - Widths are 18236, 18424, 18612 clks.
